// File: rtl/pe_eject_decoder_if.sv
// PE ejection port bundle: router handshake into the node plus the consumer read side.
interface pe_eject_decoder_if;
  logic        peso;
  logic [63:0] pedo;
  logic        pero;
  logic        rd_en;
  logic        rd_valid;
  logic [7:0]  rd_src_x;
  logic [7:0]  rd_src_y;
  logic [7:0]  rd_hop;
  logic [31:0] rd_payload;
  logic        rd_err;
  logic [15:0] pkt_cnt;
  logic [15:0] err_cnt;

  modport slave (
    input  peso, pedo, rd_en,
    output pero, rd_valid, rd_src_x, rd_src_y, rd_hop, rd_payload, rd_err,
    output pkt_cnt, err_cnt
  );

  modport master (
    output peso, pedo, rd_en,
    input  pero, rd_valid, rd_src_x, rd_src_y, rd_hop, rd_payload, rd_err,
    input  pkt_cnt, err_cnt
  );
endinterface

// File: rtl/pe_eject_decoder.sv
// Mesh PE ejection endpoint: decodes packet headers, verifies the reconstructed destination
// against this node, and queues decoded packets in a show-ahead FIFO with saturating counters.
module pe_eject_decoder #(
  parameter int unsigned MY_X  = 0,
  parameter int unsigned MY_Y  = 0,
  parameter int unsigned DEPTH = 4
) (
  input logic                clk,
  input logic                reset,
  pe_eject_decoder_if.slave  bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [7:0]  src_x;
    logic [7:0]  src_y;
    logic [7:0]  hop;
    logic [31:0] payload;
    logic        err;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_pero;
  logic [15:0]     r_pkt_cnt;
  logic [15:0]     r_err_cnt;

  logic            w_push;
  logic            w_pop;
  logic            w_valid;
  logic [CW-1:0]   w_count_next;
  logic [1:0]      w_dir;
  logic [3:0]      w_hop_x;
  logic [3:0]      w_hop_y;
  logic [7:0]      w_src_x;
  logic [7:0]      w_src_y;
  logic [7:0]      w_des_x;
  logic [7:0]      w_des_y;
  logic            w_err;
  entry_t          w_in;
  entry_t          w_head;

  // Header decode and destination reconstruction (modulo-256)
  always_comb begin
    w_dir   = bus.pedo[62:61];
    w_hop_x = bus.pedo[55:52];
    w_hop_y = bus.pedo[51:48];
    w_src_x = bus.pedo[47:40];
    w_src_y = bus.pedo[39:32];
    w_des_x = w_dir[1] ? (w_src_x + 8'(w_hop_x)) : (w_src_x - 8'(w_hop_x));
    w_des_y = w_dir[0] ? (w_src_y + 8'(w_hop_y)) : (w_src_y - 8'(w_hop_y));
    w_err   = (w_des_x != 8'(MY_X)) || (w_des_y != 8'(MY_Y)) || (bus.pedo[60:56] != 5'd0);
    w_in.src_x   = w_src_x;
    w_in.src_y   = w_src_y;
    w_in.hop     = bus.pedo[55:48];
    w_in.payload = bus.pedo[31:0];
    w_in.err     = w_err;
  end

  assign w_valid      = (r_count != '0);
  assign w_push       = bus.peso & r_pero;
  assign w_pop        = bus.rd_en & w_valid;
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_pero    <= 1'b0;
      r_pkt_cnt <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_in;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
        if (r_pkt_cnt != 16'hFFFF) r_pkt_cnt <= r_pkt_cnt + 16'd1;
        if (w_err && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_next;
      // Ready for next edge reflects occupancy after this edge's push/pop
      r_pero  <= (w_count_next < CW'(DEPTH));
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  assign bus.pero       = r_pero;
  assign bus.rd_valid   = w_valid;
  assign bus.rd_src_x   = w_valid ? w_head.src_x   : 8'd0;
  assign bus.rd_src_y   = w_valid ? w_head.src_y   : 8'd0;
  assign bus.rd_hop     = w_valid ? w_head.hop     : 8'd0;
  assign bus.rd_payload = w_valid ? w_head.payload : 32'd0;
  assign bus.rd_err     = w_valid ? w_head.err     : 1'b0;
  assign bus.pkt_cnt    = r_pkt_cnt;
  assign bus.err_cnt    = r_err_cnt;
endmodule

// File: tb/tb_pe_eject_decoder.sv
// Directed bench for pe_eject_decoder at node (1,2) with a 4-entry FIFO.
module tb_pe_eject_decoder;
  localparam int unsigned DEPTH = 4;

  logic clk;
  logic reset;
  pe_eject_decoder_if bus ();

  pe_eject_decoder #(.MY_X(1), .MY_Y(2), .DEPTH(DEPTH)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        peso;
    logic [63:0] pedo;
    logic        rd_en;
    logic        valid;
    logic [7:0]  sx;
    logic [7:0]  sy;
    logic [7:0]  hop;
    logic [31:0] pl;
    logic        err;
    logic        pero;
    logic [15:0] pkt;
    logic [15:0] errc;
  } vec_t;

  vec_t vecs [9];

  int n_pass  = 0;
  int n_total = 0;

  // Model for hand-written sequences: all packets route (2,2)->(1,2), hop 0x10, no error
  logic [31:0] q[$];
  logic        m_pero;
  logic [15:0] m_pkt;
  logic [15:0] m_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic chk_all(input string tag, input logic valid, input logic [7:0] sx,
                         input logic [7:0] sy, input logic [7:0] hop, input logic [31:0] pl,
                         input logic err, input logic pero, input logic [15:0] pkt,
                         input logic [15:0] errc);
    chk({tag, ".rd_valid"},   64'(bus.rd_valid),   64'(valid));
    chk({tag, ".rd_src_x"},   64'(bus.rd_src_x),   64'(sx));
    chk({tag, ".rd_src_y"},   64'(bus.rd_src_y),   64'(sy));
    chk({tag, ".rd_hop"},     64'(bus.rd_hop),     64'(hop));
    chk({tag, ".rd_payload"}, 64'(bus.rd_payload), 64'(pl));
    chk({tag, ".rd_err"},     64'(bus.rd_err),     64'(err));
    chk({tag, ".pero"},       64'(bus.pero),       64'(pero));
    chk({tag, ".pkt_cnt"},    64'(bus.pkt_cnt),    64'(pkt));
    chk({tag, ".err_cnt"},    64'(bus.err_cnt),    64'(errc));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mcycle(input string tag, input logic peso_i, input logic [31:0] pl,
                        input logic rd_i, output logic accepted);
    logic push;
    logic pop;
    bus.peso  = peso_i;
    bus.pedo  = {8'h00, 8'h10, 8'h02, 8'h02, pl};
    bus.rd_en = rd_i;
    push = peso_i && m_pero;
    pop  = rd_i && (q.size() > 0);
    step();
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back(pl);
      m_pkt++;
    end
    m_pero   = (q.size() < DEPTH);
    accepted = push;
    if (q.size() > 0) chk_all(tag, 1'b1, 8'h02, 8'h02, 8'h10, q[0], 1'b0, m_pero, m_pkt, m_err);
    else              chk_all(tag, 1'b0, 8'h00, 8'h00, 8'h00, 32'h0, 1'b0, m_pero, m_pkt, m_err);
  endtask

  task automatic drain(input string tag, output int n_popped, output logic [31:0] got [8]);
    logic acc;
    n_popped = 0;
    for (int i = 0; i < 8; i++) got[i] = '0;
    for (int i = 0; i < 8; i++) begin
      if (!bus.rd_valid) break;
      got[n_popped] = bus.rd_payload;
      n_popped++;
      mcycle(tag, 1'b0, 32'h0, 1'b1, acc);
    end
    bus.rd_en = 1'b0;
  endtask

  initial begin
    logic        acc;
    int          idx;
    int          npop;
    logic [31:0] got [8];
    logic [31:0] pl [6];

    vecs[0] = '{1'b1, 64'h4010_0002_8888_0000, 1'b0, 1'b1, 8'h00, 8'h02, 8'h10, 32'h8888_0000, 1'b0, 1'b1, 16'd1, 16'd0};
    vecs[1] = '{1'b0, 64'h0,                   1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 32'h0,         1'b0, 1'b1, 16'd1, 16'd0};
    vecs[2] = '{1'b1, 64'h0001_0103_DDDD_0000, 1'b1, 1'b1, 8'h01, 8'h03, 8'h01, 32'hDDDD_0000, 1'b0, 1'b1, 16'd2, 16'd0};
    vecs[3] = '{1'b1, 64'h0010_0202_AAAA_0000, 1'b1, 1'b1, 8'h02, 8'h02, 8'h10, 32'hAAAA_0000, 1'b0, 1'b1, 16'd3, 16'd0};
    vecs[4] = '{1'b1, 64'h4010_0002_8888_0000, 1'b1, 1'b1, 8'h00, 8'h02, 8'h10, 32'h8888_0000, 1'b0, 1'b1, 16'd4, 16'd0};
    vecs[5] = '{1'b0, 64'h0,                   1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 32'h0,         1'b0, 1'b1, 16'd4, 16'd0};
    vecs[6] = '{1'b1, 64'h4020_0002_8888_0000, 1'b0, 1'b1, 8'h00, 8'h02, 8'h20, 32'h8888_0000, 1'b1, 1'b1, 16'd5, 16'd1};
    vecs[7] = '{1'b1, 64'h0810_0202_AAAA_0000, 1'b1, 1'b1, 8'h02, 8'h02, 8'h10, 32'hAAAA_0000, 1'b1, 1'b1, 16'd6, 16'd2};
    vecs[8] = '{1'b0, 64'h0,                   1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 32'h0,         1'b0, 1'b1, 16'd6, 16'd2};
    for (int i = 0; i < 6; i++) pl[i] = 32'hC000_0000 + 32'(i);

    reset     = 1'b1;
    bus.peso  = 1'b1;
    bus.pedo  = 64'h4010_0002_8888_0000;
    bus.rd_en = 1'b0;
    step();
    step();
    chk_all("reset", 1'b0, 8'h00, 8'h00, 8'h00, 32'h0, 1'b0, 1'b0, 16'd0, 16'd0);
    bus.peso = 1'b0;
    reset    = 1'b0;
    step();
    chk_all("first_edge", 1'b0, 8'h00, 8'h00, 8'h00, 32'h0, 1'b0, 1'b1, 16'd0, 16'd0);

    // Delivery, in-order pops and error detection
    for (int i = 0; i < 9; i++) begin
      bus.peso  = vecs[i].peso;
      bus.pedo  = vecs[i].pedo;
      bus.rd_en = vecs[i].rd_en;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].valid, vecs[i].sx, vecs[i].sy, vecs[i].hop,
              vecs[i].pl, vecs[i].err, vecs[i].pero, vecs[i].pkt, vecs[i].errc);
    end

    q.delete();
    m_pero = 1'b1;
    m_pkt  = 16'd6;
    m_err  = 16'd2;

    // Backpressure: peso held with 6 packets, no pops
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      mcycle($sformatf("bp_fill%0d", c), 1'b1, pl[idx], 1'b0, acc);
      if (acc) idx++;
    end
    chk("bp_accepted", 64'(idx), 64'd4);
    chk("bp_pero_low", 64'(bus.pero), 64'd0);
    mcycle("bp_pop", 1'b1, pl[idx], 1'b1, acc);
    chk("bp_pop_no_accept", 64'(acc), 64'd0);
    chk("bp_pero_back", 64'(bus.pero), 64'd1);
    mcycle("bp_fifth", 1'b1, pl[idx], 1'b0, acc);
    if (acc) idx++;
    chk("bp_fifth_accepted", 64'(idx), 64'd5);
    bus.peso = 1'b0;
    drain("bp_drain", npop, got);
    chk("bp_drain_count", 64'(npop), 64'd4);
    for (int k = 0; k < 4; k++) chk($sformatf("bp_order%0d", k), 64'(got[k]), 64'(32'hC000_0001 + 32'(k)));

    // Simultaneous push and pop at three entries
    for (int c = 0; c < 3; c++) mcycle($sformatf("sp_fill%0d", c), 1'b1, 32'hD000_0000 + 32'(c), 1'b0, acc);
    mcycle("sp_both0", 1'b1, 32'hD000_0003, 1'b1, acc);
    chk("sp_pero0", 64'(bus.pero), 64'd1);
    mcycle("sp_both1", 1'b1, 32'hD000_0004, 1'b1, acc);
    chk("sp_pero1", 64'(bus.pero), 64'd1);
    bus.peso = 1'b0;
    drain("sp_drain", npop, got);
    chk("sp_drain_count", 64'(npop), 64'd3);
    for (int k = 0; k < 3; k++) chk($sformatf("sp_order%0d", k), 64'(got[k]), 64'(32'hD000_0002 + 32'(k)));

    // Asynchronous reset with two entries buffered
    mcycle("rs_fill0", 1'b1, 32'hE000_0000, 1'b0, acc);
    mcycle("rs_fill1", 1'b1, 32'hE000_0001, 1'b0, acc);
    bus.peso = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    chk("rs_async_valid", 64'(bus.rd_valid), 64'd0);
    chk("rs_async_pero",  64'(bus.pero),     64'd0);
    chk("rs_async_pkt",   64'(bus.pkt_cnt),  64'd0);
    bus.peso = 1'b1;
    bus.pedo = {8'h00, 8'h10, 8'h02, 8'h02, 32'hE000_0009};
    step();
    chk_all("rs_held", 1'b0, 8'h00, 8'h00, 8'h00, 32'h0, 1'b0, 1'b0, 16'd0, 16'd0);
    bus.peso = 1'b0;
    reset    = 1'b0;
    q.delete();
    m_pero = 1'b0;
    m_pkt  = 16'd0;
    m_err  = 16'd0;
    mcycle("rs_first_edge", 1'b0, 32'h0, 1'b0, acc);
    mcycle("rs_no_stale", 1'b0, 32'h0, 1'b1, acc);
    mcycle("rs_new_pkt", 1'b1, 32'hE000_0002, 1'b0, acc);
    mcycle("rs_new_pop", 1'b0, 32'h0, 1'b1, acc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/pe_eject_decoder.md
# pe_eject_decoder

Processing-element-side ejection endpoint for one node of the 4x4 mesh NoC. It accepts 64-bit packets from the router's PE output port using the peso/pedo/pero handshake and decodes the header. Decoding covers direction, hop counts and source coordinates; the block then reconstructs the destination each packet was addressed to and checks it against the node's own coordinates. Decoded packets are buffered in a show-ahead FIFO for the local consumer, and the block keeps saturating received and error counters.

## Interface
- MY_X, 0, x coordinate of this node (0..3)
- MY_Y, 0, y coordinate of this node (0..3)
- DEPTH, 4, FIFO entries (power of two, >=2)
- clk  input  1  clock, all state on rising edge
- reset  input  1  reset, asynchronous, active-high
- peso  input  1  router has a packet on pedo
- pedo  input  64  packet from router
- pero  output  1  block can accept a packet (registered)
- rd_en  input  1  consumer pops head entry
- rd_valid  output  1  FIFO non-empty
- rd_src_x  output  8  head source x
- rd_src_y  output  8  head source y
- rd_hop  output  8  head hop byte {hop_x,hop_y}
- rd_payload  output  32  head payload
- rd_err  output  1  head packet failed checks
- pkt_cnt  output  16  packets accepted, saturating
- err_cnt  output  16  packets with rd_err set, saturating

## Operation
- Packet fields:
  - [63] vc, ignored.
  - [62:61] dir; dir[1]=1 means +x, dir[0]=1 means +y.
  - [60:56] reserved, must be 0.
  - [55:52] hop_x; [51:48] hop_y.
  - [47:40] src_x; [39:32] src_y.
  - [31:0] payload.
- Destination reconstruction uses 8-bit modulo-256 arithmetic:
  - des_x = dir[1] ? src_x+hop_x : src_x-hop_x
  - des_y = dir[0] ? src_y+hop_y : src_y-hop_y
- err is set when any of the following holds: des_x!=MY_X, des_y!=MY_Y, or [60:56]!=0.
- Accept: a transfer happens on a rising edge with peso=1 and pero=1. Decoded fields plus err are written to the FIFO tail in that edge. peso while pero=0 is ignored; the block never captures it and the router holds the packet.
- Pop: on a rising edge with rd_en=1 and rd_valid=1, the head is removed. rd_en while empty is ignored.
- Read outputs are show-ahead and reflect the current head. When empty, rd_src_x, rd_src_y, rd_hop, rd_payload and rd_err are all 0.
- pero_next = (occupancy after this edge's push/pop) < DEPTH. Overflow is therefore impossible.
- Each accept increments pkt_cnt. Each accept with err=1 also increments err_cnt. Both counters hold at 0xFFFF.
- Simultaneous push and pop in the same edge: occupancy unchanged, pero unchanged. When full, no push can occur. A pop frees one slot and pero rises at that edge.

## Timing
- Reset (asynchronous) clears all state:
  - FIFO empty, pointers 0.
  - pero=0, rd_valid=0, all rd_* outputs 0.
  - pkt_cnt=0, err_cnt=0.
- First edge after reset deassertion: pero=1.
- Latency: a packet accepted at edge N is visible with rd_valid=1 after edge N, i.e. in cycle N+1. This holds when the FIFO was empty.
- Throughput: one packet per cycle while the consumer pops every cycle.
- Reset mid-operation: buffered packets are discarded and counters are cleared. A packet presented during reset is not accepted.

## Test plan
1. **Correct delivery.** MY_X=1, MY_Y=2; after reset, drive peso=1 for one cycle with pedo=0x4010_0002_8888_0000 (src 8 to node 9).
   - Next cycle: rd_valid=1, rd_src_x=0, rd_src_y=2, rd_hop=0x10, rd_payload=0x8888_0000, rd_err=0.
   - pkt_cnt=1, err_cnt=0.
2. **Three sources, in-order pop.** Back-to-back packets 0x0001_0103_DDDD_0000, 0x0010_0202_AAAA_0000 and 0x4010_0002_8888_0000, with rd_en held at 1.
   - Pops return sources (1,3), (2,2), (0,2) in that order, all rd_err=0.
   - pkt_cnt=3.
3. **Misrouted packet.** pedo=0x4020_0002_8888_0000 (reconstructs to (2,2)).
   - Stored with rd_err=1; err_cnt=1.
   - Separately, 0x0810_0202_AAAA_0000 (reserved bit set) also gives rd_err=1.
4. **Backpressure.** DEPTH=4, rd_en=0, peso held at 1 with 6 distinct packets.
   - Exactly 4 accepted; pero=0 after the 4th accept edge.
   - Assert rd_en for one cycle: pero returns to 1 at that edge, and the 5th packet is accepted on the next edge. No packet is lost or duplicated.
5. **Full with simultaneous traffic.** With the FIFO at 3 entries, push and pop on the same edge.
   - Occupancy stays 3, pero stays 1, and FIFO order is preserved.
6. **Reset mid-stream.** Assert reset asynchronously between edges while 2 entries are buffered.
   - Immediately: rd_valid=0, pero=0, pkt_cnt=0.
   - After deassertion: pero=1 at the first edge, and no stale entries are popped.
